// File: rtl/axiDemo_package.sv
// Shared AXI encodings, FSM state types and the request legality check
// used by both channels of the memory responder.
package axiDemo_package;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  // A request is illegal if its beat size is not the bus width, its burst
  // type is WRAP/reserved, or any word it touches lies past the memory end.
  // The final word is computed one bit wider than the start word so the
  // range check cannot wrap around.
  function automatic logic req_err(
    input logic [2:0]  size,
    input logic [2:0]  size_ok,
    input logic [1:0]  burst,
    input logic [63:0] start_word,
    input logic [7:0]  len,
    input logic [63:0] depth
  );
    logic [64:0] final_word;
    final_word = {1'b0, start_word};
    if (burst == BURST_INCR) final_word = final_word + {57'd0, len};
    return (size != size_ok) || (burst == BURST_WRAP) || (burst == BURST_RSVD) ||
           (final_word >= {1'b0, depth});
  endfunction

endpackage

// File: rtl/axi_read_if.sv
// AXI4 read address and read data channels.
interface axi_read_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) ();
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
  logic              rlast;

  modport dst (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rid, rresp, rlast
  );
  modport src (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rid, rresp, rlast
  );
endinterface

// File: rtl/axi_write_if.sv
// AXI4 write address, write data and write response channels.
interface axi_write_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) ();
  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic [ID_W-1:0]     awid;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;

  modport dst (
    input  awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bid, bresp
  );
  modport src (
    output awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid, bid, bresp
  );
endinterface

// File: rtl/axi_mem_responder_ram.sv
// Word memory built as one byte-wide array per byte lane: byte-enabled
// synchronous write, asynchronous read (a same-cycle read sees old data).
module axi_mem_responder_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic [AW-1:0]       rd_addr,
  output logic [DATA_W-1:0]   rd_data
);
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W/8; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      // Commit this byte lane when its strobe is set.
      always_ff @(posedge clk) begin
        if (wr_en && wr_strb[gi]) lane_mem[wr_addr] <= wr_data[gi*8 +: 8];
      end
      assign rd_data[gi*8 +: 8] = lane_mem[rd_addr];
    end
  endgenerate
endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backed by a word memory. Independent read and write
// FSMs, one outstanding transaction per direction, illegal requests are
// completed with SLVERR and never touch memory.
module axi_mem_responder
  import axiDemo_package::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int MEM_DEPTH = 256
) (
  input  logic     clk,
  input  logic     rst,
  axi_read_if.dst  axiRd,
  axi_write_if.dst axiWr
);
  localparam int BYTES = DATA_W / 8;
  localparam int SH    = $clog2(BYTES);
  localparam int AW    = $clog2(MEM_DEPTH);
  localparam int WA_W  = AW + 1;

  wr_state_t         w_state_reg, w_state_next;
  logic [ID_W-1:0]   w_id_reg;
  logic [WA_W-1:0]   w_addr_reg;
  logic [7:0]        w_len_reg, w_cnt_reg;
  logic [1:0]        w_burst_reg;
  logic              w_err_reg;

  rd_state_t         r_state_reg, r_state_next;
  logic [ID_W-1:0]   r_id_reg;
  logic [WA_W-1:0]   r_addr_reg;
  logic [7:0]        r_len_reg, r_cnt_reg;
  logic [1:0]        r_burst_reg;
  logic              r_err_reg;

  logic [ADDR_W-1:0] aw_word, ar_word;
  logic              aw_err, ar_err;
  logic              aw_fire, w_fire, ar_fire, r_fire;
  logic              w_last_beat, r_last_beat;
  logic [DATA_W-1:0] mem_rdata;

  assign aw_word = axiWr.awaddr >> SH;
  assign ar_word = axiRd.araddr >> SH;
  assign aw_err  = req_err(axiWr.awsize, 3'(SH), axiWr.awburst, 64'(aw_word), axiWr.awlen, 64'(MEM_DEPTH));
  assign ar_err  = req_err(axiRd.arsize, 3'(SH), axiRd.arburst, 64'(ar_word), axiRd.arlen, 64'(MEM_DEPTH));

  assign aw_fire     = axiWr.awvalid && (w_state_reg == W_IDLE);
  assign w_fire      = axiWr.wvalid  && (w_state_reg == W_DATA);
  assign ar_fire     = axiRd.arvalid && (r_state_reg == R_IDLE);
  assign r_fire      = axiRd.rready  && (r_state_reg == R_DATA);
  assign w_last_beat = (w_cnt_reg == w_len_reg);
  assign r_last_beat = (r_cnt_reg == r_len_reg);

  axi_mem_responder_ram #(.DEPTH(MEM_DEPTH), .DATA_W(DATA_W), .AW(AW)) u_ram (
    .clk     (clk),
    .wr_en   (w_fire && !w_err_reg),
    .wr_addr (w_addr_reg[AW-1:0]),
    .wr_data (axiWr.wdata),
    .wr_strb (axiWr.wstrb),
    .rd_addr (r_addr_reg[AW-1:0]),
    .rd_data (mem_rdata)
  );

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) w_state_reg <= W_IDLE;
    else     w_state_reg <= w_state_next;
  end

  // Write FSM next state: burst length, not wlast, decides the end.
  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE:  if (aw_fire) w_state_next = W_DATA;
      W_DATA:  if (w_fire && w_last_beat) w_state_next = W_RESP;
      W_RESP:  if (axiWr.bready) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  // Write channel handshake and response outputs.
  always_comb begin
    axiWr.awready = (w_state_reg == W_IDLE);
    axiWr.wready  = (w_state_reg == W_DATA);
    axiWr.bvalid  = (w_state_reg == W_RESP);
    axiWr.bid     = w_id_reg;
    axiWr.bresp   = ((w_state_reg == W_RESP) && w_err_reg) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  end

  // Write burst bookkeeping: capture on aw, advance per beat, flag a misplaced wlast.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_id_reg    <= '0;
      w_addr_reg  <= '0;
      w_len_reg   <= '0;
      w_cnt_reg   <= '0;
      w_burst_reg <= BURST_INCR;
      w_err_reg   <= 1'b0;
    end else if (aw_fire) begin
      w_id_reg    <= axiWr.awid;
      w_addr_reg  <= aw_word[WA_W-1:0];
      w_len_reg   <= axiWr.awlen;
      w_cnt_reg   <= '0;
      w_burst_reg <= axiWr.awburst;
      w_err_reg   <= aw_err;
    end else if (w_fire) begin
      w_cnt_reg <= w_cnt_reg + 8'd1;
      if (w_burst_reg == BURST_INCR) w_addr_reg <= w_addr_reg + WA_W'(1);
      if (axiWr.wlast != w_last_beat) w_err_reg <= 1'b1;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state_reg <= R_IDLE;
    else     r_state_reg <= r_state_next;
  end

  // Read FSM next state: leave after the final beat is accepted.
  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (ar_fire) r_state_next = R_DATA;
      R_DATA:  if (r_fire && r_last_beat) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read channel outputs, all derived from registers so they hold under backpressure.
  always_comb begin
    axiRd.arready = (r_state_reg == R_IDLE);
    axiRd.rvalid  = (r_state_reg == R_DATA);
    axiRd.rid     = r_id_reg;
    axiRd.rdata   = ((r_state_reg == R_DATA) && !r_err_reg) ? mem_rdata : '0;
    axiRd.rresp   = ((r_state_reg == R_DATA) && r_err_reg) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    axiRd.rlast   = (r_state_reg == R_DATA) && r_last_beat;
  end

  // Read burst bookkeeping: capture on ar, advance only on an accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_reg    <= '0;
      r_addr_reg  <= '0;
      r_len_reg   <= '0;
      r_cnt_reg   <= '0;
      r_burst_reg <= BURST_INCR;
      r_err_reg   <= 1'b0;
    end else if (ar_fire) begin
      r_id_reg    <= axiRd.arid;
      r_addr_reg  <= ar_word[WA_W-1:0];
      r_len_reg   <= axiRd.arlen;
      r_cnt_reg   <= '0;
      r_burst_reg <= axiRd.arburst;
      r_err_reg   <= ar_err;
    end else if (r_fire) begin
      r_cnt_reg <= r_cnt_reg + 8'd1;
      if (r_burst_reg == BURST_INCR) r_addr_reg <= r_addr_reg + WA_W'(1);
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: tasks issue bursts and push the
// expected responses computed from a plain word-array model; independent
// monitors pop and compare whenever the DUT hands over a B or R beat.
module tb_axi_mem_responder;
  localparam int ADDR_W = 32, DATA_W = 64, ID_W = 4, MEM_DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_read_if  #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) rd_if ();
  axi_write_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) wr_if ();

  axi_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .axiRd (rd_if),
    .axiWr (wr_if)
  );

  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;

  int checks = 0;
  int errors = 0;
  logic [63:0] ref_mem [MEM_DEPTH];
  b_exp_t b_q[$];
  r_exp_t r_q[$];
  int b_seen = 0;
  int r_seen = 0;
  bit rand_ready = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference rules: legality and which word each beat addresses.
  function automatic bit model_err(input logic [31:0] addr, input int size, input int burst, input int len);
    longint start = longint'(addr) / 8;
    longint last_w = (burst == 1) ? start + len : start;
    return (size != 3) || (burst > 1) || (last_w >= MEM_DEPTH);
  endfunction

  function automatic int beat_word(input logic [31:0] addr, input int burst, input int i);
    return (burst == 1) ? int'(addr / 8) + i : int'(addr / 8);
  endfunction

  function automatic logic ready_of(input int which);
    case (which)
      0: return wr_if.awready;
      1: return wr_if.wready;
      default: return rd_if.arready;
    endcase
  endfunction

  // Returns at the posedge on which the handshake completes.
  task automatic wait_ready(input int which, input string name);
    int t = 0;
    logic r;
    @(negedge clk);
    r = ready_of(which);
    while (!r && t < 100) begin
      @(negedge clk);
      r = ready_of(which);
      t++;
    end
    chk({name, "_ready"}, r, 1);
    @(posedge clk);
  endtask

  task automatic axi_write(input logic [31:0] addr, input int len, input logic [3:0] id,
                           input int size, input int burst,
                           input logic [63:0] data[$], input logic [7:0] strb[$], input bit wait_b);
    bit err = model_err(addr, size, burst, len);
    int n = b_seen;
    int t = 0;
    b_q.push_back('{id, err ? 2'b10 : 2'b00});
    wr_if.awvalid = 1'b1; wr_if.awaddr = addr; wr_if.awid = id;
    wr_if.awlen = 8'(len); wr_if.awsize = 3'(size); wr_if.awburst = 2'(burst);
    wait_ready(0, "aw");
    #1 wr_if.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (rand_ready && $urandom_range(0, 3) == 0) begin
        wr_if.wvalid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      wr_if.wvalid = 1'b1; wr_if.wdata = data[i]; wr_if.wstrb = strb[i]; wr_if.wlast = (i == len);
      wait_ready(1, "w");
      if (!err) begin
        int w = beat_word(addr, burst, i);
        for (int b = 0; b < 8; b++)
          if (strb[i][b]) ref_mem[w][b*8 +: 8] = data[i][b*8 +: 8];
      end
      #1;
    end
    wr_if.wvalid = 1'b0; wr_if.wlast = 1'b0;
    @(negedge clk);
    chk("b_latency", wr_if.bvalid, 1);
    if (wait_b) begin
      while (b_seen <= n && t < 2000) begin @(negedge clk); t++; end
      chk("b_done", b_seen > n, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_write(input logic [31:0] addr, input int len, input logic [3:0] id,
                            input int size, input int burst, input bit full_strb);
    logic [63:0] d[$];
    logic [7:0]  s[$];
    for (int i = 0; i <= len; i++) begin
      d.push_back({$urandom, $urandom});
      s.push_back(full_strb ? 8'hFF : 8'($urandom));
    end
    axi_write(addr, len, id, size, burst, d, s, 1'b1);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int len, input logic [3:0] id,
                          input int size, input int burst);
    bit err = model_err(addr, size, burst, len);
    int target = r_seen + len + 1;
    int t = 0;
    for (int i = 0; i <= len; i++)
      r_q.push_back('{id, err ? 64'd0 : ref_mem[beat_word(addr, burst, i)], err ? 2'b10 : 2'b00, i == len});
    rd_if.arvalid = 1'b1; rd_if.araddr = addr; rd_if.arid = id;
    rd_if.arlen = 8'(len); rd_if.arsize = 3'(size); rd_if.arburst = 2'(burst);
    wait_ready(2, "ar");
    #1 rd_if.arvalid = 1'b0;
    @(negedge clk);
    chk("ar_to_rvalid", rd_if.rvalid, 1);
    while (r_seen < target && t < 4000) begin @(negedge clk); t++; end
    chk("r_done", r_seen >= target, 1);
    @(posedge clk); #1;
  endtask

  // B monitor.
  always @(negedge clk) begin
    b_exp_t be;
    if (!rst && wr_if.bvalid && wr_if.bready) begin
      if (b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected actual bid=%0d expected none", wr_if.bid);
      end else begin
        be = b_q.pop_front();
        chk("bid", wr_if.bid, be.id);
        chk("bresp", wr_if.bresp, be.resp);
      end
      b_seen++;
    end
  end

  // R monitor, including hold-stable checks while rready is low.
  bit r_stall = 1'b0;
  logic [70:0] r_hold;
  always @(negedge clk) begin
    r_exp_t re;
    if (rst) r_stall = 1'b0;
    else begin
      if (r_stall)
        chk("r_stable", {rd_if.rvalid, rd_if.rid, rd_if.rdata, rd_if.rresp, rd_if.rlast}, {1'b1, r_hold});
      if (rd_if.rvalid && rd_if.rready) begin
        if (r_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected actual rdata=%0h expected none", rd_if.rdata);
        end else begin
          re = r_q.pop_front();
          chk("rid", rd_if.rid, re.id);
          chk("rdata", rd_if.rdata, re.data);
          chk("rresp", rd_if.rresp, re.resp);
          chk("rlast", rd_if.rlast, re.last);
        end
        r_seen++;
      end
      r_stall = rd_if.rvalid && !rd_if.rready;
      r_hold = {rd_if.rid, rd_if.rdata, rd_if.rresp, rd_if.rlast};
    end
  end

  // Random ready pattern for the randomized phase.
  always @(posedge clk) begin
    #1;
    if (rand_ready) begin
      rd_if.rready = ($urandom_range(0, 3) != 0);
      wr_if.bready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int base;
    logic [63:0] d[$];
    logic [7:0]  s[$];
    wr_if.awvalid = 0; wr_if.awaddr = 0; wr_if.awid = 0; wr_if.awlen = 0; wr_if.awsize = 3; wr_if.awburst = 1;
    wr_if.wvalid = 0; wr_if.wdata = 0; wr_if.wstrb = 0; wr_if.wlast = 0; wr_if.bready = 1;
    rd_if.arvalid = 0; rd_if.araddr = 0; rd_if.arid = 0; rd_if.arlen = 0; rd_if.arsize = 3; rd_if.arburst = 1;
    rd_if.rready = 1;

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_awready", wr_if.awready, 1);
    chk("rst_arready", rd_if.arready, 1);
    chk("rst_wready", wr_if.wready, 0);
    chk("rst_bvalid", wr_if.bvalid, 0);
    chk("rst_rvalid", rd_if.rvalid, 0);
    chk("rst_rlast", rd_if.rlast, 0);
    chk("rst_rdata", rd_if.rdata, 0);
    @(posedge clk); #1;

    // Fill the whole memory with one maximum-length burst, then read it back.
    rand_write(32'h0, 255, 4'd1, 3, 1, 1'b1);
    axi_read(32'h0, 255, 4'd2, 3, 1);

    // Directed INCR write and read-back.
    d = '{64'd1, 64'd2, 64'd3, 64'd4};
    s = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    axi_write(32'h40, 3, 4'd5, 3, 1, d, s, 1'b1);
    axi_read(32'h40, 3, 4'd9, 3, 1);

    // Byte strobes.
    d = '{64'h1122334455667788}; s = '{8'hFF};
    axi_write(32'h0, 0, 4'd2, 3, 1, d, s, 1'b1);
    d = '{64'hAAAAAAAABBBBBBBB}; s = '{8'h0F};
    axi_write(32'h0, 0, 4'd3, 3, 1, d, s, 1'b1);
    axi_read(32'h0, 0, 4'd4, 3, 1);

    // Out-of-range accesses, then confirm word 0 was not aliased.
    d = '{64'hDEADBEEFDEADBEEF, 64'hCAFEF00DCAFEF00D}; s = '{8'hFF, 8'hFF};
    axi_write(32'h800, 1, 4'd6, 3, 1, d, s, 1'b1);
    axi_read(32'h7F8, 1, 4'd7, 3, 1);
    axi_read(32'h0, 0, 4'd8, 3, 1);
    axi_read(32'h7F8, 0, 4'd8, 3, 1);

    // Read backpressure: stall 5 cycles at beat 2 of 8.
    base = r_seen;
    fork
      axi_read(32'h80, 7, 4'd10, 3, 1);
      begin
        int t = 0;
        while (r_seen < base + 2 && t < 100) begin @(negedge clk); t++; end
        @(posedge clk); #1 rd_if.rready = 1'b0;
        repeat (5) @(posedge clk);
        #1 rd_if.rready = 1'b1;
      end
    join

    // Write response backpressure: bready low 3 cycles.
    wr_if.bready = 1'b0;
    fork
      rand_write(32'h200, 1, 4'd11, 3, 1, 1'b1);
      begin
        int t = 0;
        @(negedge clk);
        while (!wr_if.bvalid && t < 100) begin @(negedge clk); t++; end
        for (int k = 0; k < 3; k++) begin
          chk("bhold_bvalid", wr_if.bvalid, 1);
          chk("bhold_awready", wr_if.awready, 0);
          @(negedge clk);
        end
        @(posedge clk); #1 wr_if.bready = 1'b1;
      end
    join

    // Reset in the middle of a 4-beat write after two beats.
    wr_if.awvalid = 1'b1; wr_if.awaddr = 32'h100; wr_if.awid = 4'd3;
    wr_if.awlen = 8'd3; wr_if.awsize = 3'd3; wr_if.awburst = 2'd1;
    wait_ready(0, "aw_abort");
    #1 wr_if.awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      logic [63:0] v;
      v = {$urandom, $urandom};
      wr_if.wvalid = 1'b1; wr_if.wdata = v; wr_if.wstrb = 8'hFF; wr_if.wlast = 1'b0;
      wait_ready(1, "w_abort");
      ref_mem[32 + i] = v;
      #1;
    end
    wr_if.wvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_bvalid", wr_if.bvalid, 0);
    chk("abort_awready", wr_if.awready, 1);
    chk("abort_wready", wr_if.wready, 0);
    @(posedge clk); #1;
    axi_read(32'h100, 1, 4'd12, 3, 1);

    // Randomized traffic with random ready patterns.
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int sel = $urandom_range(0, 9);
      int burst = (sel == 0) ? 0 : (sel == 1) ? 2 : 1;
      int size = ($urandom_range(0, 9) == 0) ? 2 : 3;
      int len = $urandom_range(0, 15);
      logic [31:0] addr = 32'($urandom_range(0, 270) * 8 + $urandom_range(0, 7));
      if (n % 2 == 0) rand_write(addr, len, 4'($urandom), size, burst, 1'b0);
      else            axi_read(addr, len, 4'($urandom), size, burst);
    end
    rand_ready = 1'b0;
    rd_if.rready = 1'b1; wr_if.bready = 1'b1;
    repeat (4) @(posedge clk);
    chk("b_queue_drained", b_q.size(), 0);
    chk("r_queue_drained", r_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
